argon_exec_pipe: RTL
====================

// Module: argon_exec_pipe
// PURPOSE
//  Parametrised successor to the Argon regfile+ALU datapath. Two-stage pipeline (EX, WB) with valid/ready
//  issue handshake, EX->WB operand forwarding, registered flags consumed by carry ops, and a multi-cycle
//  shift-add multiply FSM. Halt is a synchronous stall (clock enable), never a gated clock.
// PARAMETERS
//  DATA_W    16  datapath/register width (>=4)
//  NUM_REGS  16  register count (power of 2, >=2); SEL_W = $clog2(NUM_REGS) derived localparam
//  R0_ZERO   1   1: r0 reads 0, writes to r0 discarded; 0: r0 is a normal register
// PORTS
//  i_clk        in   1       clock
//  i_reset_n    in   1       asynchronous active-low reset
//  i_halt       in   1       stall: freezes all state, blocks issue and writeback
//  i_valid      in   1       op presented
//  o_ready      out  1       op accepted at edge when i_valid & o_ready
//  i_op         in   4       opcode (see BEHAVIOUR)
//  i_sel_a      in   SEL_W   operand A register
//  i_sel_b      in   SEL_W   operand B register
//  i_sel_w      in   SEL_W   destination register
//  i_use_imm    in   1       1: operand B = i_imm
//  i_imm        in   DATA_W  immediate
//  i_wr_en      in   1       write result to i_sel_w
//  i_flags_en   in   1       update flags register
//  o_wb_valid   out  1       WB stage holds a result this cycle
//  o_wb_sel     out  SEL_W   WB destination
//  o_wb_data    out  DATA_W  WB result
//  o_flags      out  4       {Z,S,V,C} registered
//  o_busy       out  1       MUL in progress
//  i_dbg_sel    in   SEL_W   debug read select
//  o_dbg_data   out  DATA_W  combinational regfile read (no WB bypass)
// BEHAVIOUR
//  Reset: all registers, flags, WB stage = 0; FSM=IDLE; o_ready=1 (if ~i_halt), o_wb_valid=0, o_busy=0.
//  o_ready = (state==IDLE) & ~i_halt. Accept = i_valid & o_ready.
//  Ops: 0 ADD, 1 ADC(+C), 2 SUB, 3 SBB(-C), 4 AND, 5 OR, 6 XOR, 7 NOT A, 8 SHL1 A, 9 SHR1 A,
//   10 SAR1 A, 11 MOV B, 12 MUL (low DATA_W bits), 13 CMP (=SUB, never writes), 14/15 NOP (no write, no flags).
//  Flags: Z=(res==0), S=res[MSB]. ADD/ADC: C=carry out, V=signed ovf. SUB/SBB/CMP: C=borrow (A<B+Cin unsigned),
//   V=signed ovf. Logic/MOV: C=V=0. Shifts: C=bit shifted out, V=0. MUL: C=V=(high half of full product !=0).
//  Single-cycle op accepted at edge E0: result/flags latch into WB at E0; o_wb_valid high the cycle after E0;
//   regfile write at E1 (if i_wr_en & op writes & not r0-discard). Flags register updated at E0 when i_flags_en.
//  Forwarding: if WB valid with write pending and sel matches i_sel_a/i_sel_b (nonzero when R0_ZERO), EX uses
//   o_wb_data. ADC/SBB use o_flags, already updated by previous op -> back-to-back carry chains correct.
//  MUL FSM IDLE->MUL on accept at E0 (operands captured, forwarded); one bit per edge E1..E_DATA_W;
//   at E_DATA_W result+flags enter WB, FSM->IDLE. o_ready=0, o_busy=1 between E0 and E_DATA_W.
//  Halt: no accept, MUL counter/partial product hold, WB contents hold, no regfile write, o_wb_valid forced 0;
//   on release pipeline resumes exactly where it stopped.
//  Simultaneous: WB write and new op to same dest at same edge -> WB writes, new result enters WB (no loss).
//   o_dbg_data of register being written this edge shows old value.
//  Reset mid-MUL: abort, no write, FSM=IDLE. i_valid while ~o_ready: ignored, no side effects.
// TESTING
//  1 Reset release -> o_ready=1, o_flags=0, o_dbg_data=0 for every i_dbg_sel.
//  2 Back-to-back MOV r1=0x7FFF, MOV r2=0x0001, ADD r3=r1+r2 -> r3=0x8000, flags Z0 S1 V1 C0 (forwarding).
//  3 MOV r4=0xFFFF; ADD r5=r4+1 (C=1); ADC r6=r0+0 -> r6=0x0001; CMP 1-2 -> C1 S1 Z0, no reg changes.
//  4 MUL 0x0123*0x0010 -> 0x1230, o_ready low 16 cycles, C=0; MUL 0x8000*2 -> 0x0000, Z1 C1 V1.
//  5 Halt 5 cycles mid-MUL and with WB pending -> result identical, arrives 5 cycles later, no early write.
//  6 R0_ZERO=1, NUM_REGS=8: MOV r0=0x55AA -> r0 reads 0, no forwarding; reset mid-MUL -> no write, o_ready=1.

Source files
------------

// File: rtl/argon_exec_pipe_if.sv
`default_nettype none
// argon_exec_pipe_if: issue handshake, writeback view, flags and debug port of argon_exec_pipe.
interface argon_exec_pipe_if #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16
);
  localparam int SEL_W = $clog2(NUM_REGS);

  logic              i_halt;
  logic              i_valid;
  logic              o_ready;
  logic [3:0]        i_op;
  logic [SEL_W-1:0]  i_sel_a;
  logic [SEL_W-1:0]  i_sel_b;
  logic [SEL_W-1:0]  i_sel_w;
  logic              i_use_imm;
  logic [DATA_W-1:0] i_imm;
  logic              i_wr_en;
  logic              i_flags_en;
  logic              o_wb_valid;
  logic [SEL_W-1:0]  o_wb_sel;
  logic [DATA_W-1:0] o_wb_data;
  logic [3:0]        o_flags;
  logic              o_busy;
  logic [SEL_W-1:0]  i_dbg_sel;
  logic [DATA_W-1:0] o_dbg_data;

  modport master (
    output i_halt, i_valid, i_op, i_sel_a, i_sel_b, i_sel_w, i_use_imm, i_imm,
           i_wr_en, i_flags_en, i_dbg_sel,
    input  o_ready, o_wb_valid, o_wb_sel, o_wb_data, o_flags, o_busy, o_dbg_data
  );

  modport slave (
    input  i_halt, i_valid, i_op, i_sel_a, i_sel_b, i_sel_w, i_use_imm, i_imm,
           i_wr_en, i_flags_en, i_dbg_sel,
    output o_ready, o_wb_valid, o_wb_sel, o_wb_data, o_flags, o_busy, o_dbg_data
  );
endinterface
`default_nettype wire

// File: rtl/argon_exec_pipe.sv
`default_nettype none
// argon_exec_pipe: EX/WB regfile+ALU pipeline with WB->EX forwarding, registered
// {Z,S,V,C} flags and a bit-serial shift-add multiplier; halt acts as a clock enable.
module argon_exec_pipe #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter bit R0_ZERO  = 1'b1
) (
  input wire               i_clk,
  input wire               i_reset_n,
  argon_exec_pipe_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_REGS);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int MSB   = DATA_W - 1;

  localparam logic [3:0] OP_ADD = 4'd0,  OP_ADC = 4'd1,  OP_SUB = 4'd2,  OP_SBB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4,  OP_OR  = 4'd5,  OP_XOR = 4'd6,  OP_NOT = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8,  OP_SHR = 4'd9,  OP_SAR = 4'd10, OP_MOV = 4'd11;
  localparam logic [3:0] OP_MUL = 4'd12, OP_CMP = 4'd13;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t state, state_next;

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [3:0]          flags;
  logic                wb_valid;
  logic                wb_we;
  logic [SEL_W-1:0]    wb_sel;
  logic [DATA_W-1:0]   wb_data;

  logic [2*DATA_W-1:0] mcand;
  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] acc_next;
  logic [DATA_W-1:0]   mplier;
  logic [CNT_W-1:0]    cnt;
  logic [SEL_W-1:0]    mul_sel;
  logic                mul_we;
  logic                mul_flags_en;
  logic                mul_last;
  logic                mul_done;
  logic [3:0]          mul_flags;

  logic                ready;
  logic                busy;
  logic                accept;
  logic                fwd_a, fwd_b;
  logic [DATA_W-1:0]   rf_a, rf_b, op_a, op_b;

  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c, alu_v;
  logic                alu_writes, alu_flags_ok;
  logic [3:0]          alu_flags;

  function automatic logic is_r0(input logic [SEL_W-1:0] sel);
    return R0_ZERO && (sel == '0);
  endfunction

  // wb_we is already cleared for discarded r0 writes, so r0 is never forwarded
  assign rf_a  = is_r0(bus.i_sel_a) ? '0 : regs[bus.i_sel_a];
  assign rf_b  = is_r0(bus.i_sel_b) ? '0 : regs[bus.i_sel_b];
  assign fwd_a = wb_valid && wb_we && (wb_sel == bus.i_sel_a);
  assign fwd_b = wb_valid && wb_we && (wb_sel == bus.i_sel_b);
  assign op_a  = fwd_a ? wb_data : rf_a;
  assign op_b  = bus.i_use_imm ? bus.i_imm : (fwd_b ? wb_data : rf_b);

  assign accept = bus.i_valid && ready;

  always_comb begin
    sum          = '0;
    alu_res      = '0;
    alu_c        = 1'b0;
    alu_v        = 1'b0;
    alu_writes   = 1'b1;
    alu_flags_ok = 1'b1;
    case (bus.i_op)
      OP_ADD, OP_ADC: begin
        sum     = {1'b0, op_a} + {1'b0, op_b} + {{DATA_W{1'b0}}, (bus.i_op == OP_ADC) & flags[0]};
        alu_res = sum[MSB:0];
        alu_c   = sum[DATA_W];
        alu_v   = (op_a[MSB] == op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        // bit DATA_W of the extended difference is the borrow
        sum        = {1'b0, op_a} - {1'b0, op_b} - {{DATA_W{1'b0}}, (bus.i_op == OP_SBB) & flags[0]};
        alu_res    = sum[MSB:0];
        alu_c      = sum[DATA_W];
        alu_v      = (op_a[MSB] != op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
        alu_writes = (bus.i_op != OP_CMP);
      end
      OP_AND: alu_res = op_a & op_b;
      OP_OR:  alu_res = op_a | op_b;
      OP_XOR: alu_res = op_a ^ op_b;
      OP_NOT: alu_res = ~op_a;
      OP_SHL: begin
        alu_res = {op_a[MSB-1:0], 1'b0};
        alu_c   = op_a[MSB];
      end
      OP_SHR: begin
        alu_res = {1'b0, op_a[MSB:1]};
        alu_c   = op_a[0];
      end
      OP_SAR: begin
        alu_res = {op_a[MSB], op_a[MSB:1]};
        alu_c   = op_a[0];
      end
      OP_MOV: alu_res = op_b;
      OP_MUL: alu_res = '0;
      default: begin
        alu_writes   = 1'b0;
        alu_flags_ok = 1'b0;
      end
    endcase
  end

  assign alu_flags = {alu_res == '0, alu_res[MSB], alu_v, alu_c};

  assign acc_next  = acc + (mplier[0] ? mcand : '0);
  assign mul_last  = (cnt == CNT_W'(DATA_W - 1));
  assign mul_done  = (state == ST_MUL) && mul_last && !bus.i_halt;
  assign mul_flags = {acc_next[MSB:0] == '0, acc_next[MSB],
                      acc_next[2*DATA_W-1:DATA_W] != '0, acc_next[2*DATA_W-1:DATA_W] != '0};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    busy       = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = !bus.i_halt;
        if (bus.i_valid && !bus.i_halt && (bus.i_op == OP_MUL)) state_next = ST_MUL;
      end
      ST_MUL: begin
        busy = 1'b1;
        if (mul_last && !bus.i_halt) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      flags        <= '0;
      wb_valid     <= 1'b0;
      wb_we        <= 1'b0;
      wb_sel       <= '0;
      wb_data      <= '0;
      mcand        <= '0;
      acc          <= '0;
      mplier       <= '0;
      cnt          <= '0;
      mul_sel      <= '0;
      mul_we       <= 1'b0;
      mul_flags_en <= 1'b0;
    end else if (!bus.i_halt) begin
      if (wb_valid && wb_we) regs[wb_sel] <= wb_data;
      wb_valid <= 1'b0;

      if (accept && (bus.i_op != OP_MUL)) begin
        wb_valid <= 1'b1;
        wb_we    <= bus.i_wr_en && alu_writes && !is_r0(bus.i_sel_w);
        wb_sel   <= bus.i_sel_w;
        wb_data  <= alu_res;
        if (bus.i_flags_en && alu_flags_ok) flags <= alu_flags;
      end else if (mul_done) begin
        wb_valid <= 1'b1;
        wb_we    <= mul_we;
        wb_sel   <= mul_sel;
        wb_data  <= acc_next[MSB:0];
        if (mul_flags_en) flags <= mul_flags;
      end

      if (accept && (bus.i_op == OP_MUL)) begin
        mcand        <= {{DATA_W{1'b0}}, op_a};
        mplier       <= op_b;
        acc          <= '0;
        cnt          <= '0;
        mul_sel      <= bus.i_sel_w;
        mul_we       <= bus.i_wr_en && !is_r0(bus.i_sel_w);
        mul_flags_en <= bus.i_flags_en;
      end else if (state == ST_MUL) begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CNT_W'(1);
      end
    end
  end

  assign bus.o_ready    = ready;
  assign bus.o_busy     = busy;
  assign bus.o_wb_valid = wb_valid && !bus.i_halt;
  assign bus.o_wb_sel   = wb_sel;
  assign bus.o_wb_data  = wb_data;
  assign bus.o_flags    = flags;
  assign bus.o_dbg_data = is_r0(bus.i_dbg_sel) ? '0 : regs[bus.i_dbg_sel];

endmodule
`default_nettype wire
